// File: rtl/impix_indicator_ctrl_if.sv
// impix_indicator_ctrl_if: Avalon-MM slave bus bundle for the indicator controller.
// Signals: avs_address (word address), avs_write/avs_writedata (single-cycle write),
//          avs_read (read strobe), avs_readdata (read data, latency 1).
// Modports: master drives address/strobes/write data, slave returns read data.
interface impix_indicator_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;
    modport master (output avs_address, avs_write, avs_writedata, avs_read, input avs_readdata);
    modport slave (input avs_address, avs_write, avs_writedata, avs_read, output avs_readdata);
endinterface

// File: rtl/impix_indicator_ctrl.sv
// impix_indicator_ctrl: NUM_CH LED indicator channels (OFF/ON/BLINK/PWM) behind an Avalon-MM slave.
// Ports: clk_clk (clock), reset_reset (sync active-high reset),
//        avs (impix_indicator_ctrl_if.slave bus), indicators_export (registered indicator outputs).
// Map: 0 CTRL [0]enable [1]invert; 1 PRESCALE; 2+n CHn [2:0]mode [15:8]duty [23:16]period.
// Option: define IMPIX_IND_ONESHOT_EN to build mode 4 (one-shot pulse of duty ticks, self-clearing).
module impix_indicator_ctrl #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 3,
    parameter int PRE_W  = 24
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    impix_indicator_ctrl_if.slave avs,
    output logic [NUM_CH-1:0]     indicators_export
);
    logic [1:0]        ctrl_q, ctrl_d;
    logic [PRE_W-1:0]  pre_q, pre_d, pcnt_q, pcnt_d;
    logic [2:0]        mode_q [NUM_CH];
    logic [2:0]        mode_d [NUM_CH];
    logic [7:0]        duty_q [NUM_CH];
    logic [7:0]        duty_d [NUM_CH];
    logic [7:0]        period_q [NUM_CH];
    logic [7:0]        period_d [NUM_CH];
    logic [7:0]        cnt_q [NUM_CH];
    logic [7:0]        cnt_d [NUM_CH];
    logic [NUM_CH-1:0] phase_q, phase_d, wrap, raw, out_q, out_d;
    logic [31:0]       rdata_q, rdata_d, rmux;
    logic              tick;

    assign tick = pcnt_q == pre_q;

    always_comb begin
        ctrl_d  = ctrl_q;
        pre_d   = pre_q;
        pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
        phase_d = phase_q;
        wrap    = '0;
        raw     = '0;
        rmux    = '0;
        if (avs.avs_address == ADDR_W'(0)) rmux = {30'b0, ctrl_q};
        if (avs.avs_address == ADDR_W'(1)) rmux = 32'(pre_q);
        if (avs.avs_write && avs.avs_address == ADDR_W'(0)) ctrl_d = avs.avs_writedata[1:0];
        if (avs.avs_write && avs.avs_address == ADDR_W'(1)) begin
            pre_d  = avs.avs_writedata[PRE_W-1:0];
            pcnt_d = '0;
        end
        for (int n = 0; n < NUM_CH; n++) begin
            mode_d[n]   = mode_q[n];
            duty_d[n]   = duty_q[n];
            period_d[n] = period_q[n];
            cnt_d[n]    = cnt_q[n];
`ifdef IMPIX_IND_ONESHOT_EN
            // a one-shot counts ticks from its write, so it must not wrap at period
            wrap[n] = cnt_q[n] == period_q[n] && mode_q[n] != 3'd4;
            raw[n]  = mode_q[n] == 3'd1 ? 1'b1 :
                      mode_q[n] == 3'd2 ? phase_q[n] :
                      mode_q[n] == 3'd3 || mode_q[n] == 3'd4 ? cnt_q[n] < duty_q[n] : 1'b0;
            // the tick that ends the duty-th tick period (or the first tick when duty=0) retires the pulse
            if (tick && mode_q[n] == 3'd4 && {1'b0, cnt_q[n]} + 9'd1 >= {1'b0, duty_q[n]}) mode_d[n] = '0;
`else
            wrap[n] = cnt_q[n] == period_q[n];
            raw[n]  = mode_q[n] == 3'd1 ? 1'b1 :
                      mode_q[n] == 3'd2 ? phase_q[n] :
                      mode_q[n] == 3'd3 ? cnt_q[n] < duty_q[n] : 1'b0;
`endif
            if (tick) begin
                cnt_d[n]   = wrap[n] ? '0 : cnt_q[n] + 1'b1;
                phase_d[n] = phase_q[n] ^ wrap[n];
            end
            if (avs.avs_address == ADDR_W'(n + 2)) begin
                rmux = {8'b0, period_q[n], duty_q[n], 5'b0, mode_q[n]};
                if (avs.avs_write) begin
                    mode_d[n]   = avs.avs_writedata[2:0];
                    duty_d[n]   = avs.avs_writedata[15:8];
                    period_d[n] = avs.avs_writedata[23:16];
                    cnt_d[n]    = '0;
                    phase_d[n]  = 1'b0;
                end
            end
        end
        rdata_d = avs.avs_read ? rmux : rdata_q;
        out_d   = ctrl_q[0] ? raw ^ {NUM_CH{ctrl_q[1]}} : '0;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            ctrl_q  <= '0;
            pre_q   <= '0;
            pcnt_q  <= '0;
            phase_q <= '0;
            out_q   <= '0;
            rdata_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                mode_q[n]   <= '0;
                duty_q[n]   <= '0;
                period_q[n] <= '0;
                cnt_q[n]    <= '0;
            end
        end else begin
            ctrl_q  <= ctrl_d;
            pre_q   <= pre_d;
            pcnt_q  <= pcnt_d;
            phase_q <= phase_d;
            out_q   <= out_d;
            rdata_q <= rdata_d;
            for (int n = 0; n < NUM_CH; n++) begin
                mode_q[n]   <= mode_d[n];
                duty_q[n]   <= duty_d[n];
                period_q[n] <= period_d[n];
                cnt_q[n]    <= cnt_d[n];
            end
        end
    end

    assign indicators_export = out_q;
    assign avs.avs_readdata  = rdata_q;
endmodule

// File: tb/tb_impix_indicator_ctrl.sv
// tb_impix_indicator_ctrl: directed self-checking bench for impix_indicator_ctrl (NUM_CH=4, ADDR_W=3, PRE_W=24).
module tb_impix_indicator_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ind;
    logic [31:0] d;
    int          k, c;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    impix_indicator_ctrl_if #(.ADDR_W(3)) bus ();

    impix_indicator_ctrl #(.NUM_CH(4), .ADDR_W(3), .PRE_W(24)) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .avs(bus),
        .indicators_export(ind)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.avs_address   = a;
        bus.avs_writedata = v;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read = 1'b0;
        v = bus.avs_readdata;
    endtask

    task automatic wait_chg(input int b, output int cycles);
        logic prev;
        prev   = ind[b];
        cycles = 0;
        while (ind[b] == prev && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic count_hi(input int b, input int len, output int hi);
        hi = 0;
        repeat (len) begin
            @(negedge clk);
            if (ind[b]) hi++;
        end
    endtask

    initial begin
        bus.avs_address   = '0;
        bus.avs_writedata = '0;
        bus.avs_write     = 1'b0;
        bus.avs_read      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_out", 32'(ind), 32'h0);
        chk("reset_rdata", bus.avs_readdata, 32'h0);
        for (int a = 0; a < 6; a++) begin
            rd(3'(a), d);
            chk($sformatf("reset_rd%0d", a), d, 32'h0);
        end

        wr(0, 32'h1);
        wr(2, 32'h1);
        chk("on_1clk", 32'(ind), 32'h0);
        @(negedge clk);
        chk("on_2clk", 32'(ind), 32'h1);
        wr(0, 32'h3);
        @(negedge clk);
        chk("invert", 32'(ind), 32'hE);

        wr(0, 32'h1);
        wr(1, 32'd9);
        wr(3, 32'h0001_0002);
        wait_chg(1, k);
        wait_chg(1, k);
        chk("blink_iv1", k, 20);
        wait_chg(1, k);
        chk("blink_iv2", k, 20);
        wr(0, 32'h0);
        @(negedge clk);
        c = 0;
        repeat (40) begin
            @(negedge clk);
            if (ind != 4'h0) c++;
        end
        chk("disable_zero", c, 0);

        wr(0, 32'h1);
        wr(1, 32'd0);
        wr(4, 32'h0007_0303);
        repeat (2) @(negedge clk);
        count_hi(2, 16, c);
        chk("pwm_3of8", c, 6);
        wr(4, 32'h0007_0003);
        repeat (2) @(negedge clk);
        count_hi(2, 16, c);
        chk("pwm_duty0", c, 0);
        wr(4, 32'h0007_C803);
        repeat (2) @(negedge clk);
        count_hi(2, 16, c);
        chk("pwm_duty200", c, 16);

        wr(1, 32'd9);
        wr(5, 32'h0000_0002);
        repeat (4) @(negedge clk);
        wr(1, 32'd9);
        wait_chg(3, k);
        chk("pre_restart", k, 11);
        @(negedge clk);
        bus.avs_address   = 3'd5;
        bus.avs_writedata = 32'h0005_0A03;
        bus.avs_write     = 1'b1;
        bus.avs_read      = 1'b1;
        @(negedge clk);
        bus.avs_write = 1'b0;
        bus.avs_read  = 1'b0;
        chk("rw_old", bus.avs_readdata, 32'h0000_0002);
        repeat (3) @(negedge clk);
        chk("rd_hold", bus.avs_readdata, 32'h0000_0002);
        rd(5, d);
        chk("rw_new", d, 32'h0005_0A03);

        wr(1, 32'd0);
        wr(2, 32'h0);
        repeat (3) @(negedge clk);
        chk("ch0_off", 32'(ind[0]), 32'h0);
        wr(2, 32'h0000_0504);
        count_hi(0, 12, c);
`ifdef IMPIX_IND_ONESHOT_EN
        chk("oneshot_len", c, 5);
        rd(2, d);
        chk("oneshot_rb", d, 32'h0000_0500);
`else
        chk("mode4_off", c, 0);
        rd(2, d);
        chk("mode4_rb", d, 32'h0000_0504);
`endif

        wr(1, 32'hFFFF_FFFF);
        rd(1, d);
        chk("pre_unused", d, 32'h00FF_FFFF);
        wr(5, 32'hFFFF_FFFF);
        rd(5, d);
        chk("ch_unused", d, 32'h00FF_FF07);
        wr(7, 32'h1234_5678);
        rd(7, d);
        chk("unmapped7", d, 32'h0);
        rd(6, d);
        chk("unmapped6", d, 32'h0);

        wr(0, 32'h3);
        rd(0, d);
        chk("ctrl_rb", d, 32'h3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out", 32'(ind), 32'h0);
        chk("midrst_rdata", bus.avs_readdata, 32'h0);
        rd(0, d);
        chk("midrst_ctrl", d, 32'h0);
        rd(3, d);
        chk("midrst_ch1", d, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
